ir_cam_sequencer: RTL and testbench

- Owns the shared i2c_master instance that talks to the IR camera at I2C address 0x58.
- After reset, sequences the six-register camera init (two bytes per write), then polls the camera at a fixed rate: a one-byte pointer write of 0x36, then a four-byte read.
- Decodes blob 0 from the read into 10-bit x/y, a 4-bit size, and a valid flag, for the tracking/drawing logic downstream.
- Supervises every i2c_master transaction with a timeout; on timeout it backs off and re-runs the init.

---
 rtl/ir_cam_sequencer_if.sv | 21 ++
 rtl/ir_cam_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_ir_cam_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ir_cam_sequencer_if.sv
// I2C master request/response bundle between the camera sequencer (master) and the shared i2c_master (slave).
// Pure wiring, no latency; ready/start handshake, sequencer waits on i2c_ready.
interface ir_cam_sequencer_if;
    logic        i2c_ready;
    logic [95:0] i2c_rdata;
    logic        i2c_start;
    logic [6:0]  i2c_addr;
    logic [95:0] i2c_data;
    logic [4:0]  i2c_packets;
    logic        i2c_rw;

    modport master (
        input  i2c_ready, i2c_rdata,
        output i2c_start, i2c_addr, i2c_data, i2c_packets, i2c_rw
    );

    modport slave (
        output i2c_ready, i2c_rdata,
        input  i2c_start, i2c_addr, i2c_data, i2c_packets, i2c_rw
    );
endinterface

// File: rtl/ir_cam_sequencer.sv
// IR camera init + periodic blob-0 poll over a shared i2c_master, with per-state timeout and backoff.
// Blob outputs update one cycle after the read completes; stalls on i2c_ready, timeout recovers via re-init.
module ir_cam_sequencer #(
    parameter logic [6:0] I2C_ADDR       = 7'h58,
    parameter int         SETTLE_CYCLES  = 600000,
    parameter int         POLL_CYCLES    = 120000,
    parameter int         TIMEOUT_CYCLES = 240000
) (
    input  logic                       clk,
    input  logic                       reset,
    ir_cam_sequencer_if.master         bus,
    output logic                       config_done,
    output logic [9:0]                 blob_x,
    output logic [9:0]                 blob_y,
    output logic [3:0]                 blob_size,
    output logic                       blob_valid,
    output logic                       sample_stb,
    output logic                       err_timeout
);
    localparam int MAX_SP  = (SETTLE_CYCLES > POLL_CYCLES) ? SETTLE_CYCLES : POLL_CYCLES;
    localparam int MAX_CYC = (MAX_SP > TIMEOUT_CYCLES) ? MAX_SP : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] POLL_LAST   = CW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_BOOT, S_CFG_START, S_CFG_WAIT, S_CFG_SETTLE, S_POLL_IDLE,
        S_PTR_START, S_PTR_WAIT, S_RD_START, S_RD_WAIT, S_LATCH, S_BACKOFF
    } state_t;

    function automatic logic [15:0] cfg_entry(input logic [2:0] i);
        case (i)
            3'd0:    cfg_entry = 16'h3001;
            3'd1:    cfg_entry = 16'h3008;
            3'd2:    cfg_entry = 16'h0690;
            3'd3:    cfg_entry = 16'h08C0;
            3'd4:    cfg_entry = 16'h1A40;
            default: cfg_entry = 16'h3333;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] poll_q, poll_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [95:0]   data_q, data_d;
    logic [4:0]    packets_q, packets_d;
    logic          rw_q, rw_d;
    logic          done_q, done_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [3:0]    size_q, size_d;
    logic          valid_q, valid_d;
    logic          stb_q, stb_d;
    logic          err_q, err_d;
    logic          is_txn, poll_phase;
    logic          unused_rdata;

    assign unused_rdata = ^{bus.i2c_rdata[95:32], bus.i2c_rdata[31:24]};

    assign is_txn = state_q inside {S_CFG_START, S_CFG_WAIT, S_PTR_START,
                                    S_PTR_WAIT, S_RD_START, S_RD_WAIT};
    assign poll_phase = state_q inside {S_POLL_IDLE, S_PTR_START, S_PTR_WAIT,
                                        S_RD_START, S_RD_WAIT, S_LATCH};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        data_d    = data_q;
        packets_d = packets_q;
        rw_d      = rw_q;
        done_d    = done_q;
        x_d       = x_q;
        y_d       = y_q;
        size_d    = size_q;
        valid_d   = valid_q;
        stb_d     = 1'b0;
        err_d     = err_q;

        // Poll timer runs across the whole poll cycle so the period stays exact; saturates if stalled.
        if (poll_phase && (poll_q != '1))
            poll_d = poll_q + 1'b1;

        case (state_q)
            S_BOOT: if (bus.i2c_ready) begin
                state_d   = S_CFG_START;
                data_d    = {80'b0, cfg_entry(idx_q)};
                packets_d = 5'd2;
                rw_d      = 1'b0;
            end
            S_CFG_START: if (!bus.i2c_ready) state_d = S_CFG_WAIT;
            S_CFG_WAIT: if (bus.i2c_ready) begin
                state_d = S_CFG_SETTLE;
                cnt_d   = '0;
            end
            S_CFG_SETTLE: if (cnt_q == SETTLE_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd5) begin
                    done_d  = 1'b1;
                    poll_d  = '0;
                    state_d = S_POLL_IDLE;
                end else begin
                    state_d   = S_CFG_START;
                    data_d    = {80'b0, cfg_entry(idx_q + 3'd1)};
                    packets_d = 5'd2;
                    rw_d      = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_POLL_IDLE: if (poll_q >= POLL_LAST) begin
                poll_d    = '0;
                state_d   = S_PTR_START;
                data_d    = 96'h36;
                packets_d = 5'd1;
                rw_d      = 1'b0;
            end
            S_PTR_START: if (!bus.i2c_ready) state_d = S_PTR_WAIT;
            S_PTR_WAIT: if (bus.i2c_ready) begin
                state_d   = S_RD_START;
                data_d    = '0;
                packets_d = 5'd4;
                rw_d      = 1'b1;
            end
            S_RD_START: if (!bus.i2c_ready) state_d = S_RD_WAIT;
            S_RD_WAIT:  if (bus.i2c_ready) state_d = S_LATCH;
            S_LATCH: begin
                x_d     = {bus.i2c_rdata[5:4], bus.i2c_rdata[23:16]};
                y_d     = {bus.i2c_rdata[7:6], bus.i2c_rdata[15:8]};
                size_d  = bus.i2c_rdata[3:0];
                valid_d = !((x_d == 10'h3FF) && (y_d == 10'h3FF));
                stb_d   = 1'b1;
                state_d = S_POLL_IDLE;
            end
            S_BACKOFF: if (cnt_q == SETTLE_LAST) begin
                cnt_d   = '0;
                state_d = S_BOOT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_BOOT;
        endcase

        if (is_txn && (state_d == state_q) && (tmo_q == TMO_LAST)) begin
            state_d = S_BACKOFF;
            err_d   = 1'b1;
            done_d  = 1'b0;
            valid_d = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end

        tmo_d = (is_txn && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_BOOT;
            idx_q     <= '0;
            cnt_q     <= '0;
            poll_q    <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            packets_q <= '0;
            rw_q      <= 1'b1;
            done_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            size_q    <= '0;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            packets_q <= packets_d;
            rw_q      <= rw_d;
            done_q    <= done_d;
            x_q       <= x_d;
            y_q       <= y_d;
            size_q    <= size_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
            err_q     <= err_d;
        end
    end

    assign bus.i2c_start   = state_q inside {S_CFG_START, S_PTR_START, S_RD_START};
    assign bus.i2c_addr    = I2C_ADDR;
    assign bus.i2c_data    = data_q;
    assign bus.i2c_packets = packets_q;
    assign bus.i2c_rw      = rw_q;

    assign config_done = done_q;
    assign blob_x      = x_q;
    assign blob_y      = y_q;
    assign blob_size   = size_q;
    assign blob_valid  = valid_q;
    assign sample_stb  = stb_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_ir_cam_sequencer.sv
// Directed bench for ir_cam_sequencer with a behavioural i2c_master (ready drops 2 cycles after start, done after 20).
module tb_ir_cam_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ir_cam_sequencer_if bus();

    logic       config_done, blob_valid, sample_stb, err_timeout;
    logic [9:0] blob_x, blob_y;
    logic [3:0] blob_size;

    ir_cam_sequencer #(
        .I2C_ADDR(7'h58), .SETTLE_CYCLES(10), .POLL_CYCLES(200), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .config_done(config_done), .blob_x(blob_x), .blob_y(blob_y),
        .blob_size(blob_size), .blob_valid(blob_valid),
        .sample_stb(sample_stb), .err_timeout(err_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // i2c_master model and start/ready monitor
    logic        m_ready = 1'b1;
    logic [31:0] rd_word = 32'h0;
    assign bus.i2c_ready = m_ready;
    assign bus.i2c_rdata = {64'b0, rd_word};

    int          cyc = 0;
    logic        start_p = 1'b0;
    logic        busy = 1'b0;
    int          mcnt = 0;
    int          cfg_seen = 0;
    int          stall_target = -1;
    logic        stalled = 1'b0;
    int          rise_cyc = 0;
    int          fall_cyc = 0;
    logic        ready_seen = 1'b1;
    int          overlap_err = 0;
    int          nlog = 0;
    logic [15:0] log_dat [0:63];
    logic [4:0]  log_pk  [0:63];
    logic        log_rw  [0:63];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        start_p <= bus.i2c_start;
        if (bus.i2c_start && !start_p) begin
            if (!ready_seen) overlap_err <= overlap_err + 1;
            ready_seen <= 1'b0;
            rise_cyc   <= cyc;
            if (nlog < 64) begin
                log_dat[nlog] <= bus.i2c_data[15:0];
                log_pk[nlog]  <= bus.i2c_packets;
                log_rw[nlog]  <= bus.i2c_rw;
                nlog <= nlog + 1;
            end
            if (bus.i2c_packets == 5'd2) cfg_seen <= cfg_seen + 1;
        end else if (bus.i2c_ready && !bus.i2c_start) begin
            ready_seen <= 1'b1;
        end
        if (!bus.i2c_start && start_p) fall_cyc <= cyc;

        if (busy) begin
            mcnt <= mcnt + 1;
            if (mcnt == 1) m_ready <= 1'b0;
            if (mcnt == 19) begin
                m_ready <= 1'b1;
                busy    <= 1'b0;
            end
        end else if (bus.i2c_start && !start_p) begin
            if (bus.i2c_packets == 5'd2 && cfg_seen + 1 == stall_target) begin
                stalled <= 1'b1;
            end else begin
                busy <= 1'b1;
                mcnt <= 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_start"}, 96'(bus.i2c_start), 96'd0);
        chk({pfx, "_rw"}, 96'(bus.i2c_rw), 96'd1);
        chk({pfx, "_packets"}, 96'(bus.i2c_packets), 96'd0);
        chk({pfx, "_data"}, bus.i2c_data, 96'd0);
        chk({pfx, "_addr"}, 96'(bus.i2c_addr), 96'h58);
        chk({pfx, "_config_done"}, 96'(config_done), 96'd0);
        chk({pfx, "_blob_x"}, 96'(blob_x), 96'd0);
        chk({pfx, "_blob_y"}, 96'(blob_y), 96'd0);
        chk({pfx, "_blob_size"}, 96'(blob_size), 96'd0);
        chk({pfx, "_blob_valid"}, 96'(blob_valid), 96'd0);
        chk({pfx, "_sample_stb"}, 96'(sample_stb), 96'd0);
        chk({pfx, "_err_timeout"}, 96'(err_timeout), 96'd0);
    endtask

    initial begin
        logic [15:0] exp_cfg [0:5];
        int t1, t2, t3, base, rs;
        logic got;
        exp_cfg[0] = 16'h3001; exp_cfg[1] = 16'h3008; exp_cfg[2] = 16'h0690;
        exp_cfg[3] = 16'h08C0; exp_cfg[4] = 16'h1A40; exp_cfg[5] = 16'h3333;

        // reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        reset = 1'b1;

        // init sequence
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (config_done) begin got = 1'b1; break; end
        end
        chk("init_config_done", 96'(got), 96'd1);
        chk("init_txn_count", 96'(nlog), 96'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("init_data%0d", k), 96'(log_dat[k]), 96'(exp_cfg[k]));
            chk($sformatf("init_pk%0d", k), 96'(log_pk[k]), 96'd2);
            chk($sformatf("init_rw%0d", k), 96'(log_rw[k]), 96'd0);
        end

        // first poll: valid blob
        rd_word = 32'h0034129A;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (sample_stb) begin got = 1'b1; break; end
        end
        t1 = cyc;
        chk("poll1_stb", 96'(got), 96'd1);
        chk("ptr_data", 96'(log_dat[6]), 96'h36);
        chk("ptr_pk", 96'(log_pk[6]), 96'd1);
        chk("ptr_rw", 96'(log_rw[6]), 96'd0);
        chk("rd_pk", 96'(log_pk[7]), 96'd4);
        chk("rd_rw", 96'(log_rw[7]), 96'd1);
        chk("blob1_x", 96'(blob_x), 96'h134);
        chk("blob1_y", 96'(blob_y), 96'h212);
        chk("blob1_size", 96'(blob_size), 96'hA);
        chk("blob1_valid", 96'(blob_valid), 96'd1);
        @(posedge clk); #1;
        chk("stb_one_cycle", 96'(sample_stb), 96'd0);
        chk("blob1_x_hold", 96'(blob_x), 96'h134);

        // second poll: no blob
        rd_word = 32'h00FFFFFF;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (sample_stb) begin got = 1'b1; break; end
        end
        t2 = cyc;
        chk("poll2_stb", 96'(got), 96'd1);
        chk("poll_period1", 96'(t2 - t1), 96'd200);
        chk("blob2_x", 96'(blob_x), 96'h3FF);
        chk("blob2_y", 96'(blob_y), 96'h3FF);
        chk("blob2_size", 96'(blob_size), 96'hF);
        chk("blob2_valid", 96'(blob_valid), 96'd0);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (sample_stb) begin got = 1'b1; break; end
        end
        t3 = cyc;
        chk("poll3_stb", 96'(got), 96'd1);
        chk("poll_period2", 96'(t3 - t2), 96'd200);

        // reset in the middle of the read transaction
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (bus.i2c_rw && bus.i2c_packets == 5'd4 && !bus.i2c_start && !bus.i2c_ready) begin
                got = 1'b1; break;
            end
        end
        chk("rd_wait_reached", 96'(got), 96'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst1");
        base = nlog;
        stall_target = cfg_seen + 3;
        @(negedge clk);
        reset = 1'b1;

        // third init write is never acknowledged
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (stalled) begin got = 1'b1; break; end
        end
        chk("stall_reached", 96'(got), 96'd1);
        rs = rise_cyc;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (fall_cyc > rs) begin got = 1'b1; break; end
        end
        chk("timeout_start_drop", 96'(got), 96'd1);
        chk("timeout_start_len", 96'(fall_cyc - rs), 96'd50);
        chk("timeout_err", 96'(err_timeout), 96'd1);
        chk("timeout_cfg_done", 96'(config_done), 96'd0);
        chk("reinit_first", 96'(log_dat[base]), 96'h3001);
        chk("stalled_entry", 96'(log_dat[base + 2]), 96'h0690);

        // recovery: full init again
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (config_done) begin got = 1'b1; break; end
        end
        chk("recover_config_done", 96'(got), 96'd1);
        chk("recover_txn_count", 96'(nlog - base), 96'd9);
        for (int k = 0; k < 6; k++)
            chk($sformatf("recover_data%0d", k), 96'(log_dat[base + 3 + k]), 96'(exp_cfg[k]));
        chk("err_sticky", 96'(err_timeout), 96'd1);
        chk("no_start_overlap", 96'(overlap_err), 96'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
